// File: rtl/mem_multicut.sv
// Memory-bus multi-cut: spill-register request path, plain-register response path, read throttling.
// Optional macro MEM_MULTICUT_RSP_CHECK_EN enables the sticky spurious-response flag on err_o.
module mem_multicut #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned NumReqCuts     = 1,
  parameter int unsigned NumRspCuts     = 1,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned StrbWidth     = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic                 we_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [StrbWidth-1:0] strb_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 req_o,
  input  logic                 gnt_i,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 we_o,
  output logic [DataWidth-1:0] wdata_o,
  output logic [StrbWidth-1:0] strb_o,
  input  logic                 rvalid_i,
  input  logic [DataWidth-1:0] rdata_i,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned PldWidth = 1 + StrbWidth + AddrWidth + DataWidth;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                throttle;
  logic                rd_hs;

  logic [NumReqCuts:0] req_vld;
  logic [NumReqCuts:0] req_rdy;
  logic [NumReqCuts:0] stg_occ;
  logic [PldWidth-1:0] req_pld [NumReqCuts+1];

  logic [NumRspCuts:0] rsp_vld;
  logic [DataWidth-1:0] rsp_dat [NumRspCuts+1];

  // Reads are held off upstream once the outstanding budget is used up; writes always pass.
  assign throttle = !we_i && (cnt_q == CntMax);
  assign gnt_o    = req_rdy[0] && !throttle;
  assign rd_hs    = req_i && gnt_o && !we_i;

  assign req_vld[0]          = req_i && !throttle;
  assign req_pld[0]          = {we_i, strb_i, addr_i, wdata_i};
  assign req_rdy[NumReqCuts] = gnt_i;
  assign stg_occ[0]          = 1'b0;

  for (genvar k = 0; k < NumReqCuts; k++) begin : g_req_cut
    logic                a_vld_q, a_vld_d, b_vld_q, b_vld_d;
    logic [PldWidth-1:0] a_pld_q, a_pld_d, b_pld_q, b_pld_d;
    logic                in_hs;

    // Slot a drives the output; slot b catches the beat accepted while a is stalled.
    always_comb begin
      in_hs   = req_vld[k] && !b_vld_q;
      a_vld_d = a_vld_q;
      a_pld_d = a_pld_q;
      b_vld_d = b_vld_q;
      b_pld_d = b_pld_q;
      if (!a_vld_q || req_rdy[k+1]) begin
        if (b_vld_q) begin
          a_vld_d = 1'b1;
          a_pld_d = b_pld_q;
          b_vld_d = 1'b0;
        end else begin
          a_vld_d = in_hs;
          if (in_hs) a_pld_d = req_pld[k];
        end
      end else if (in_hs) begin
        b_vld_d = 1'b1;
        b_pld_d = req_pld[k];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        a_vld_q <= 1'b0;
        b_vld_q <= 1'b0;
        a_pld_q <= '0;
        b_pld_q <= '0;
      end else begin
        a_vld_q <= a_vld_d;
        b_vld_q <= b_vld_d;
        a_pld_q <= a_pld_d;
        b_pld_q <= b_pld_d;
      end
    end

    assign req_rdy[k]   = !b_vld_q;
    assign req_vld[k+1] = a_vld_q;
    assign req_pld[k+1] = a_pld_q;
    assign stg_occ[k+1] = a_vld_q || b_vld_q;
  end

  assign req_o = req_vld[NumReqCuts];
  assign {we_o, strb_o, addr_o, wdata_o} = req_pld[NumReqCuts];

  assign rsp_vld[0] = rvalid_i;
  assign rsp_dat[0] = rdata_i;

  for (genvar k = 0; k < NumRspCuts; k++) begin : g_rsp_cut
    logic                 vld_q;
    logic [DataWidth-1:0] dat_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else begin
        vld_q <= rsp_vld[k];
        dat_q <= rsp_dat[k];
      end
    end

    assign rsp_vld[k+1] = vld_q;
    assign rsp_dat[k+1] = dat_q;
  end

  assign rvalid_o = rsp_vld[NumRspCuts];
  assign rdata_o  = rsp_dat[NumRspCuts];

  always_comb begin
    cnt_d = cnt_q;
    if (rd_hs && !rvalid_o && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (!rd_hs && rvalid_o && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy_o = (|stg_occ) || (cnt_q != '0);

`ifdef MEM_MULTICUT_RSP_CHECK_EN
  logic err_q, err_d;

  // A response with nothing outstanding (and no read landing this cycle) is a protocol error.
  always_comb begin
    err_d = err_q;
    if (rvalid_o && (cnt_q == '0) && !rd_hs) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
